// File: rtl/instr_info_table_param.sv
// Per-wavefront instruction-info table with valid bits, occupancy count and sticky overwrite error.
// Optional build macro INSTR_INFO_REG_RD_EN registers the read ports (1-cycle latency).
module instr_info_table_param #(
  parameter int DATA_W       = 64,
  parameter int NUM_WF       = 40,
  parameter int WFID_W       = 6,
  parameter int NUM_RD_PORTS = 5,
  parameter int CNT_W        = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [WFID_W-1:0]                wr_wfid,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             clr_en,
  input  logic [WFID_W-1:0]                clr_wfid,
  input  logic [NUM_RD_PORTS*WFID_W-1:0]   rd_wfid,
  output logic [NUM_RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]          rd_valid,
  output logic [CNT_W-1:0]                 occupancy,
  output logic                             ovw_err,
  output logic [WFID_W-1:0]                ovw_err_wfid
);

  localparam logic [WFID_W:0] NumWfIdx = (WFID_W+1)'(NUM_WF);
  localparam logic [CNT_W:0]  NumWfCnt = (CNT_W+1)'(NUM_WF);

  logic [DATA_W-1:0] data_q [NUM_WF];
  logic [NUM_WF-1:0] valid_q;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              ovwErr_q, ovwErr_d;
  logic [WFID_W-1:0] ovwWfid_q, ovwWfid_d;

  logic              wrOk, clrOk, sameIdx;
  logic              wrNew, clrDec, ovwHit;
  logic [CNT_W:0]    occWide;

  assign wrOk    = wr_en  && ({1'b0, wr_wfid}  < NumWfIdx);
  assign clrOk   = clr_en && ({1'b0, clr_wfid} < NumWfIdx);
  assign sameIdx = (wr_wfid == clr_wfid);

  // A write to the entry being retired in the same cycle is a normal refill, not an overwrite.
  always_comb begin
    wrNew     = wrOk && !valid_q[wr_wfid];
    clrDec    = clrOk && valid_q[clr_wfid] && !(wrOk && sameIdx);
    ovwHit    = wrOk && valid_q[wr_wfid] && !(clrOk && sameIdx);
    occWide   = {1'b0, occ_q} + (CNT_W+1)'(wrNew) - (CNT_W+1)'(clrDec);
    occ_d     = occWide[CNT_W-1:0];
    ovwErr_d  = ovwErr_q | ovwHit;
    ovwWfid_d = (ovwHit && !ovwErr_q) ? wr_wfid : ovwWfid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        data_q[i] <= '0;
      end
      valid_q   <= '0;
      occ_q     <= '0;
      ovwErr_q  <= 1'b0;
      ovwWfid_q <= '0;
    end else begin
      occ_q     <= occ_d;
      ovwErr_q  <= ovwErr_d;
      ovwWfid_q <= ovwWfid_d;
      if (clrOk) begin
        valid_q[clr_wfid] <= 1'b0;
      end
      if (wrOk) begin
        valid_q[wr_wfid] <= 1'b1;
        data_q[wr_wfid]  <= wr_data;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (occWide <= NumWfCnt)
        else $error("occupancy out of range: next=%0d", occWide);
    end
  end
`endif

  assign occupancy    = occ_q;
  assign ovw_err      = ovwErr_q;
  assign ovw_err_wfid = ovwWfid_q;

  logic [NUM_RD_PORTS*DATA_W-1:0] rdDataComb;
  logic [NUM_RD_PORTS-1:0]        rdValidComb;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gRd
    logic [WFID_W-1:0] addr;
    logic              inRange;
    logic              bypass;
    assign addr    = rd_wfid[p*WFID_W +: WFID_W];
    assign inRange = ({1'b0, addr} < NumWfIdx);
    assign bypass  = wr_en && (wr_wfid == addr) && inRange;
    assign rdDataComb[p*DATA_W +: DATA_W] = bypass ? wr_data : (inRange ? data_q[addr] : '0);
    assign rdValidComb[p] = bypass | (inRange & valid_q[addr]);
  end

`ifdef INSTR_INFO_REG_RD_EN
  logic [NUM_RD_PORTS*DATA_W-1:0] rdData_q;
  logic [NUM_RD_PORTS-1:0]        rdValid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdData_q  <= '0;
      rdValid_q <= '0;
    end else begin
      rdData_q  <= rdDataComb;
      rdValid_q <= rdValidComb;
    end
  end

  assign rd_data  = rdData_q;
  assign rd_valid = rdValid_q;
`else
  assign rd_data  = rdDataComb;
  assign rd_valid = rdValidComb;
`endif

endmodule

// File: tb/tb_instr_info_table_param.sv
// Self-checking bench for instr_info_table_param: directed steps followed by random traffic
// checked against a table-of-entries reference model.
module tb_instr_info_table_param;

  localparam int DATA_W = 64;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int NPORTS = 5;
  localparam int CNT_W  = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      wrEn;
  logic [WFID_W-1:0]         wrWfid;
  logic [DATA_W-1:0]         wrData;
  logic                      clrEn;
  logic [WFID_W-1:0]         clrWfid;
  logic [NPORTS*WFID_W-1:0]  rdWfid;
  logic [NPORTS*DATA_W-1:0]  rdData;
  logic [NPORTS-1:0]         rdValid;
  logic [CNT_W-1:0]          occupancy;
  logic                      ovwErr;
  logic [WFID_W-1:0]         ovwErrWfid;

  always #5 clk = ~clk;

  instr_info_table_param #(
    .DATA_W(DATA_W), .NUM_WF(NUM_WF), .WFID_W(WFID_W), .NUM_RD_PORTS(NPORTS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wrEn), .wr_wfid(wrWfid), .wr_data(wrData),
    .clr_en(clrEn), .clr_wfid(clrWfid),
    .rd_wfid(rdWfid), .rd_data(rdData), .rd_valid(rdValid),
    .occupancy(occupancy), .ovw_err(ovwErr), .ovw_err_wfid(ovwErrWfid)
  );

  // Reference model: the table as plain arrays; occupancy is simply the count of valid entries.
  logic [DATA_W-1:0] mData [NUM_WF];
  bit                mValid [NUM_WF];
  bit                mOvw;
  int                mOvwWfid;
  int                checks;
  int                errors;
`ifdef INSTR_INFO_REG_RD_EN
  logic [DATA_W-1:0] pipeData [NPORTS];
  logic              pipeValid [NPORTS];
`endif

  function automatic int occCount();
    int n = 0;
    for (int i = 0; i < NUM_WF; i++) n += int'(mValid[i]);
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic expRead(input int a, output logic [DATA_W-1:0] d, output logic v);
    if (a < NUM_WF && wrEn && int'(wrWfid) == a) begin
      d = wrData; v = 1'b1;
    end else if (a < NUM_WF) begin
      d = mData[a]; v = mValid[a];
    end else begin
      d = '0; v = 1'b0;
    end
  endtask

  task automatic modelUpdate();
    int w, c;
    w = int'(wrWfid);
    c = int'(clrWfid);
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        mData[i] = '0; mValid[i] = 1'b0;
      end
      mOvw = 1'b0; mOvwWfid = 0;
    end else begin
      if (wrEn && w < NUM_WF && mValid[w] && !(clrEn && c == w)) begin
        if (!mOvw) mOvwWfid = w;
        mOvw = 1'b1;
      end
      if (clrEn && c < NUM_WF) mValid[c] = 1'b0;
      if (wrEn && w < NUM_WF) begin
        mValid[w] = 1'b1; mData[w] = wrData;
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input int ww, input logic [DATA_W-1:0] wd,
                               input logic ce, input int cw,
                               input int r0, input int r1, input int r2, input int r3, input int r4);
    int r [NPORTS];
    r = '{r0, r1, r2, r3, r4};
    wrEn = we; wrWfid = WFID_W'(ww); wrData = wd;
    clrEn = ce; clrWfid = WFID_W'(cw);
    for (int p = 0; p < NPORTS; p++) rdWfid[p*WFID_W +: WFID_W] = WFID_W'(r[p]);
  endtask

  // One clock: check reads before the edge, update the model at the edge, check state after it.
  task automatic tick();
    logic [DATA_W-1:0] d;
    logic              v;
    #1;
    for (int p = 0; p < NPORTS; p++) begin
      expRead(int'(rdWfid[p*WFID_W +: WFID_W]), d, v);
`ifdef INSTR_INFO_REG_RD_EN
      pipeData[p]  = rst ? d : '0;
      pipeValid[p] = rst ? v : 1'b0;
`else
      checkOutput($sformatf("rd_data%0d", p), rdData[p*DATA_W +: DATA_W], d);
      checkOutput($sformatf("rd_valid%0d", p), 64'(rdValid[p]), 64'(v));
`endif
    end
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput("occupancy", 64'(occupancy), 64'(occCount()));
    checkOutput("ovw_err", 64'(ovwErr), 64'(mOvw));
    checkOutput("ovw_err_wfid", 64'(ovwErrWfid), 64'(mOvwWfid));
`ifdef INSTR_INFO_REG_RD_EN
    for (int p = 0; p < NPORTS; p++) begin
      checkOutput($sformatf("rd_data%0d", p), rdData[p*DATA_W +: DATA_W], pipeData[p]);
      checkOutput($sformatf("rd_valid%0d", p), 64'(rdValid[p]), 64'(pipeValid[p]));
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NUM_WF; i++) begin
      mData[i] = '0; mValid[i] = 1'b0;
    end
    mOvw = 1'b0; mOvwWfid = 0;

    rst = 1'b0;
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 0, 39, 0, 39, 0);
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("occ_reset", 64'(occupancy), 64'd0);

    applyStimulus(1'b1, 3, 64'hDEAD_BEEF_0000_0003, 1'b0, 0, 3, 0, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 3, 3, 3, 3, 3);
    tick();
    checkOutput("occ_one", 64'(occupancy), 64'd1);

    // Refill wfid 3 together with its retire so the fill does not count as an overwrite.
    for (int i = 0; i < NUM_WF; i++) begin
      applyStimulus(1'b1, i, 64'hA5A5_0000_0000_0000 | 64'(i), (i == 3), 3,
                    i, (i + 1) % NUM_WF, 3, 45, 39);
      tick();
    end
    checkOutput("occ_full", 64'(occupancy), 64'd40);
    checkOutput("ovw_after_fill", 64'(ovwErr), 64'd0);

    applyStimulus(1'b0, 0, '0, 1'b1, 7, 7, 7, 0, 39, 45);
    tick();
    checkOutput("occ_clr7", 64'(occupancy), 64'd39);
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 7, 7, 7, 7, 7);
    tick();
    applyStimulus(1'b1, 45, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 45, 45, 45, 45, 7);
    tick();
    checkOutput("occ_wr45", 64'(occupancy), 64'd39);

    applyStimulus(1'b1, 12, 64'h12, 1'b1, 12, 12, 12, 0, 0, 0);
    tick();
    checkOutput("ovw_clrwr12", 64'(ovwErr), 64'd0);
    checkOutput("occ_clrwr12", 64'(occupancy), 64'd39);
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 12, 12, 12, 12, 12);
    tick();

    applyStimulus(1'b1, 5, 64'h5555, 1'b0, 0, 5, 0, 0, 0, 0);
    tick();
    checkOutput("ovw_set", 64'(ovwErr), 64'd1);
    checkOutput("ovw_wfid5", 64'(ovwErrWfid), 64'd5);
    applyStimulus(1'b1, 9, 64'h9999, 1'b0, 0, 9, 5, 0, 0, 0);
    tick();
    checkOutput("ovw_wfid_sticky", 64'(ovwErrWfid), 64'd5);

    rst = 1'b0;
    applyStimulus(1'b1, 20, 64'h2020, 1'b0, 0, 20, 5, 9, 12, 3);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 20, 5, 9, 12, 3);
    tick();
    checkOutput("occ_midreset", 64'(occupancy), 64'd0);
    checkOutput("ovw_midreset", 64'(ovwErr), 64'd0);

    applyStimulus(1'b1, 3, 64'hDEAD_BEEF_0000_0003, 1'b0, 0, 3, 3, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0, 0, 3, 3, 3, 3, 3);
    tick();

    repeat (400) begin
      int ww, cw;
      ww = int'($urandom_range(0, 47));
      cw = ($urandom_range(0, 7) == 0) ? ww : int'($urandom_range(0, 47));
      rst = ($urandom_range(0, 79) != 0);
      applyStimulus($urandom_range(0, 2) != 0, ww, {$urandom, $urandom},
                    $urandom_range(0, 2) == 0, cw,
                    ($urandom_range(0, 3) == 0) ? ww : int'($urandom_range(0, 47)),
                    int'($urandom_range(0, 47)), int'($urandom_range(0, 47)),
                    cw, int'($urandom_range(0, 47)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_info_table_param.md
Name: instr_info_table_param

Overview:
Parametrised per-wavefront instruction-info table for the issue stage. Decode writes one entry per cycle, indexed by wavefront ID. The table serves NUM_RD_PORTS independent read ports, each with same-cycle write bypass. Unlike the fixed 40-entry table, each entry carries a valid bit with a retire/clear port, an occupancy counter, and a sticky overwrite-error flag. It sits between decode and the issue/scoreboard logic.

Parameters:
DATA_W, 64, width of one instruction-info entry
NUM_WF, 40, number of entries (wavefronts per CU)
WFID_W, 6, width of a wavefront ID; NUM_WF <= 2**WFID_W
NUM_RD_PORTS, 5, number of read ports
CNT_W, 6, occupancy counter width; 2**CNT_W > NUM_WF

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (state cleared on any rising clk edge with rst==0)
wr_en  in  1  decode write valid
wr_wfid  in  WFID_W  decode write index
wr_data  in  DATA_W  decode write data
clr_en  in  1  retire/clear valid
clr_wfid  in  WFID_W  clear index
rd_wfid  in  NUM_RD_PORTS*WFID_W  packed read indices; port p is bits [p*WFID_W +: WFID_W]
rd_data  out  NUM_RD_PORTS*DATA_W  packed read data, same packing
rd_valid  out  NUM_RD_PORTS  per-port entry-valid
occupancy  out  CNT_W  number of valid entries
ovw_err  out  1  sticky: a write hit an already-valid entry that was not cleared in the same cycle
ovw_err_wfid  out  WFID_W  wfid of the first overwrite since reset

Behaviour:
- Reset (rst==0 at clk edge):
  - all entry data = 0, all valid = 0, occupancy = 0, ovw_err = 0, ovw_err_wfid = 0.
  - Pending wr_en/clr_en in that cycle are ignored.
  - Reset mid-stream simply discards table contents.
- Write: when wr_en and wr_wfid < NUM_WF, at the clk edge entry[wr_wfid].data <= wr_data and valid <= 1. wr_wfid >= NUM_WF is ignored (no state change, no error).
- Clear: when clr_en and clr_wfid < NUM_WF, entry[clr_wfid].valid <= 0. Data is retained.
  - Clearing an invalid entry is a no-op.
  - Out-of-range clr_wfid is ignored.
- Simultaneous write and clear to the same wfid: write wins; entry ends valid with the new data. This is the back-to-back retire/decode case and is not an overwrite error.
- Read (combinational, 0-cycle latency), per port p, with a = rd_wfid[p]:
  - Bypass: if wr_en and wr_wfid == a and a < NUM_WF, then rd_data[p] = wr_data and rd_valid[p] = 1.
  - Else if a < NUM_WF: rd_data[p] = entry[a].data, rd_valid[p] = entry[a].valid. A same-cycle clear does not affect the read; it shows the pre-edge valid.
  - Else: rd_data[p] = 0, rd_valid[p] = 0.
  - All ports are independent; any number may read the same index.
- Occupancy (next value):
  - +1 if the write targets an invalid entry.
  - -1 if the clear targets a valid entry that is not also written this cycle.
  - Write and clear of different entries in one cycle apply both (net 0 when both count).
  - Write plus clear of the same valid entry: unchanged.
  - Never wraps: occupancy is bounded 0..NUM_WF by construction. An implementation must assert (simulation only) if the next value would leave this range.
- Overwrite error:
  - Set when wr_en hits a valid in-range entry that is not cleared in the same cycle.
  - On the first set, ovw_err_wfid <= wr_wfid; later overwrites do not update it.
  - Cleared only by reset.
  - The write itself still takes effect.

Optional Feature:
INSTR_INFO_REG_RD_EN
- Defined: rd_data and rd_valid are registered; 1-cycle latency.
  - The registered value is the combinational result defined above, including bypass, sampled at the edge.
  - Both outputs reset to 0.
  - A clear at edge N is reflected in a read issued in cycle N+1 (output in cycle N+2).
- Undefined: purely combinational read path as described, 0 latency.
- occupancy and ovw_err are registered state in both builds.

Test Plan:
- Reset, then read all NUM_RD_PORTS at wfid 0 and 39 -> rd_data = 0, rd_valid = 0, occupancy = 0, ovw_err = 0.
- Write wfid 3 = 64'hDEAD_BEEF_0000_0003 with port 0 reading wfid 3 in the same cycle -> port 0 shows the bypass value, valid = 1. Next cycle, ports 0-4 all read 3 -> same data, valid = 1, occupancy = 1.
- Write wfids 0..39, then clear wfid 7 -> occupancy goes 40 -> 39. Read 7 -> rd_valid = 0, data retained. A write to wfid 45 -> ignored; reading 45 returns 0/0.
- Same-cycle clear and write to valid wfid 12 (data = 64'h12) -> no ovw_err, occupancy unchanged, next read = 64'h12, valid 1.
- Write valid wfid 5 again without a clear -> ovw_err = 1, ovw_err_wfid = 5. A later overwrite of wfid 9 leaves ovw_err_wfid = 5.
- Assert rst=0 for one cycle mid-stream with wr_en=1 -> all state zero next cycle, the write is dropped. With INSTR_INFO_REG_RD_EN defined, repeat the bypass test -> data appears one cycle later.
